// File: rtl/lock_pkg.sv
// Shared constants and key-event encoding for the lock datapath:
// used by the input conditioner and the lock sequence FSM.
package lock_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT  = 1_000_000;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    KEY_A = 2'd1,
    KEY_B = 2'd2
  } key_event_e;

endpackage

// File: rtl/key_debounce.sv
// One push-button lane: 2-flop synchroniser, debounce counter, stable level
// and a registered single-cycle pulse on every clean 0->1 press.
module key_debounce
  import lock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != stable) begin
        // Flip only after DEBOUNCE_CYCLES consecutive differing samples;
        // the press pulse leaves on the same edge the stable level rises.
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable <= sync2;
          cnt    <= '0;
          press  <= sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lock_key_conditioner.sv
// Conditions two raw buttons into single-cycle key events a/b plus zero.
// Define KEYIN_TIMEOUT_EN to add the inactivity timeout pulse.
module lock_key_conditioner
  import lock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic zero,
  output logic timeout
);

  logic       a_press;
  logic       b_press;
  key_event_e key_event;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw   (a_raw),
    .press (a_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw   (b_raw),
    .press (b_press)
  );

  // A simultaneous press is treated as the wrong key, so B takes priority.
  always_comb begin
    key_event = NONE;
    if (b_press) begin
      key_event = KEY_B;
    end else if (a_press) begin
      key_event = KEY_A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a    <= 1'b0;
      b    <= 1'b0;
      zero <= 1'b1;
    end else begin
      a    <= (key_event == KEY_A);
      b    <= (key_event == KEY_B);
      zero <= (key_event == NONE);
    end
  end

`ifdef KEYIN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] idle_cnt;
  logic          armed;

  // A key event on the terminal-count edge re-arms instead of timing out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      armed    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (key_event != NONE) begin
        armed    <= 1'b1;
        idle_cnt <= '0;
      end else if (armed) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout  <= 1'b1;
          armed    <= 1'b0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lock_key_conditioner.sv
// Directed bench for lock_key_conditioner with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=50; a sample-history model is checked every cycle.
module tb_lock_key_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned T = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a, b, zero, timeout;

  lock_key_conditioner #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_raw   (a_raw),
    .b_raw   (b_raw),
    .a       (a),
    .b       (b),
    .zero    (zero),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each key: raw samples reach the debouncer two edges late; the stable level
  // flips once the last D delivered samples (since the previous flip) all differ.
  bit          rq  [2][$];
  bit          win [2][$];
  bit          stab[2];
  bit          pend_a, pend_b;
  bit          exp_a, exp_b, exp_to;
  bit          armed;
  int unsigned idle;

  always @(posedge clk or posedge reset) begin
    bit raw   [2];
    bit press [2];
    bit s;
    bit all_diff;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        rq[k].delete();
        win[k].delete();
        stab[k] = 1'b0;
      end
      pend_a = 0; pend_b = 0;
      exp_a = 0; exp_b = 0; exp_to = 0;
      armed = 0; idle = 0;
    end else begin
      raw[0] = a_raw;
      raw[1] = b_raw;
      exp_a  = pend_a;
      exp_b  = pend_b;
      exp_to = 0;
`ifdef KEYIN_TIMEOUT_EN
      if (exp_a || exp_b) begin
        armed = 1; idle = 0;
      end else if (armed) begin
        idle++;
        if (idle == T) begin
          exp_to = 1;
          armed  = 0;
        end
      end
`endif
      for (int k = 0; k < 2; k++) begin
        press[k] = 0;
        s = 0;
        if (rq[k].size() == 2) s = rq[k].pop_front();
        rq[k].push_back(raw[k]);
        win[k].push_back(s);
        if (win[k].size() > D) void'(win[k].pop_front());
        all_diff = (win[k].size() == D);
        foreach (win[k][i]) if (win[k][i] == stab[k]) all_diff = 0;
        if (all_diff) begin
          stab[k]  = ~stab[k];
          press[k] = stab[k];
          win[k].delete();
        end
      end
      pend_b = press[1];
      pend_a = press[0] & ~press[1];
    end
  end

  // ---------------- per-cycle compare ----------------
  int unsigned a_times[$], b_times[$], to_times[$];

  always @(negedge clk) begin
    chk("a", a, exp_a);
    chk("b", b, exp_b);
    chk("zero", zero, !(exp_a || exp_b));
    chk("timeout", timeout, exp_to);
    if (a) a_times.push_back(cyc);
    if (b) b_times.push_back(cyc);
    if (timeout) to_times.push_back(cyc);
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    a_times.delete();
    b_times.delete();
    to_times.delete();
  endtask

  int unsigned base;
  int unsigned bl[14] = '{1, 3, 2, 1, 2, 3, 1, 1, 3, 2, 3, 2, 3, 3};

  initial begin
    // Reset state
    tick(3);
    chk("reset_a", a, 0);
    chk("reset_b", b, 0);
    chk("reset_zero", zero, 1);
    chk("reset_timeout", timeout, 0);
    reset = 1'b0;
    tick(5);

    // Clean A press: first sampled at edge base+10, pulse after edge base+16
    clear_log();
    base = cyc;
    tick(9);
    a_raw = 1'b1;
    tick(20);
    a_raw = 1'b0;
    tick(20);
    chk("clean_a_count", a_times.size(), 1);
    if (a_times.size() == 1) chk("clean_a_edge", a_times[0] - base, 16);
    chk("clean_b_count", b_times.size(), 0);

    // Bounce rejection: pulses of 1..3 cycles never reach the stable level
    clear_log();
    for (int i = 0; i < 14; i++) begin
      a_raw = (i % 2 == 0);
      tick(bl[i]);
    end
    a_raw = 1'b0;
    tick(15);
    chk("bounce_a_count", a_times.size(), 0);
    chk("bounce_b_count", b_times.size(), 0);

    // Simultaneous press counts as B
    clear_log();
    base = cyc;
    tick(9);
    a_raw = 1'b1;
    b_raw = 1'b1;
    tick(12);
    a_raw = 1'b0;
    b_raw = 1'b0;
    tick(15);
    chk("simul_a_count", a_times.size(), 0);
    chk("simul_b_count", b_times.size(), 1);
    if (b_times.size() == 1) chk("simul_b_edge", b_times[0] - base, 16);

    // Reset two cycles into debounce while key held
    clear_log();
    a_raw = 1'b1;
    tick(2);
    reset = 1'b1;
    #1;
    chk("midrst_zero", zero, 1);
    tick(2);
    reset = 1'b0;
    base = cyc;
    tick(15);
    a_raw = 1'b0;
    tick(15);
    chk("midrst_a_count", a_times.size(), 1);
    if (a_times.size() == 1) chk("midrst_a_edge", a_times[0] - base, 7);

    // Sequence A, B, A: each held 10 and released 10
    clear_log();
    base = cyc;
    a_raw = 1'b1; tick(10); a_raw = 1'b0; tick(10);
    b_raw = 1'b1; tick(10); b_raw = 1'b0; tick(10);
    a_raw = 1'b1; tick(10); a_raw = 1'b0; tick(15);
    chk("seq_a_count", a_times.size(), 2);
    chk("seq_b_count", b_times.size(), 1);
    if (a_times.size() == 2 && b_times.size() == 1) begin
      chk("seq_a0_edge", a_times[0] - base, 7);
      chk("seq_b0_edge", b_times[0] - base, 27);
      chk("seq_a1_edge", a_times[1] - base, 47);
    end
    tick(60);

`ifdef KEYIN_TIMEOUT_EN
    // One press then idle: timeout 50 cycles after the a pulse, once
    clear_log();
    base = cyc;
    a_raw = 1'b1; tick(10); a_raw = 1'b0;
    tick(120);
    chk("to_a_count", a_times.size(), 1);
    chk("to_count", to_times.size(), 1);
    if (to_times.size() == 1) chk("to_edge", to_times[0] - base, 57);

    // Second press lands 49 cycles after the first: timeout re-times
    clear_log();
    base = cyc;
    a_raw = 1'b1; tick(10); a_raw = 1'b0;
    tick(39);
    a_raw = 1'b1; tick(10); a_raw = 1'b0;
    tick(100);
    chk("to49_a_count", a_times.size(), 2);
    if (a_times.size() == 2) chk("to49_a1_edge", a_times[1] - base, 56);
    chk("to49_count", to_times.size(), 1);
    if (to_times.size() == 1) chk("to49_edge", to_times[0] - base, 106);

    // Second press exactly at the terminal count: key wins
    clear_log();
    base = cyc;
    a_raw = 1'b1; tick(10); a_raw = 1'b0;
    tick(40);
    a_raw = 1'b1; tick(10); a_raw = 1'b0;
    tick(100);
    chk("to50_a_count", a_times.size(), 2);
    if (a_times.size() == 2) chk("to50_a1_edge", a_times[1] - base, 57);
    chk("to50_count", to_times.size(), 1);
    if (to_times.size() == 1) chk("to50_edge", to_times[0] - base, 107);
`else
    chk("no_timeout_seen", to_times.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
